// File: rtl/sift_pkg.sv
// Shared constants and helpers for the SIFT scale-space front end.
// Kernel defaults are the fixed-point (sum = 256) Gaussian taps for sigma 1.6.
package sift_pkg;

  localparam int unsigned PIX_W = 8;
  localparam int unsigned WIN   = 11;
  localparam int unsigned CNT_W = 21;
  localparam int unsigned ROW_W = PIX_W * WIN;

  localparam int unsigned GAUSS_K0 = 64;
  localparam int unsigned GAUSS_K1 = 53;
  localparam int unsigned GAUSS_K2 = 29;
  localparam int unsigned GAUSS_K3 = 11;
  localparam int unsigned GAUSS_K4 = 3;
  localparam int unsigned GAUSS_K5 = 0;

  // Pixel j of a window row; pixel 0 is the leftmost, in the low byte.
  function automatic logic [PIX_W-1:0] win_pix(input logic [ROW_W-1:0] row,
                                               input int unsigned j);
    return row[j*PIX_W +: PIX_W];
  endfunction

endpackage

// File: rtl/gauss_blur11x11_if.sv
// Window-in / blurred-pixel-out bundle between block11x11, the blur and the DoG stage.
interface gauss_blur11x11_if;
  import sift_pkg::*;

  logic [ROW_W-1:0] win1, win2, win3, win4, win5, win6, win7, win8, win9, win10, win11;
  logic             win_valid;
  logic             frame_end;
  logic [PIX_W-1:0] dout;
  logic             dout_valid;
  logic             frame_done;
  logic [CNT_W-1:0] out_cnt;

  modport master (
    output win1, win2, win3, win4, win5, win6, win7, win8, win9, win10, win11,
    output win_valid, frame_end,
    input  dout, dout_valid, frame_done, out_cnt
  );

  modport slave (
    input  win1, win2, win3, win4, win5, win6, win7, win8, win9, win10, win11,
    input  win_valid, frame_end,
    output dout, dout_valid, frame_done, out_cnt
  );

endinterface

// File: rtl/gauss_fir11.sv
// Symmetric 11-tap FIR: registered pre-add of mirrored taps, then registered MAC.
// Output is IN_W+8 bits wide, exact for any kernel whose taps sum to 256.
module gauss_fir11
  import sift_pkg::*;
#(
  parameter int unsigned IN_W = 8,
  parameter int unsigned K0   = GAUSS_K0,
  parameter int unsigned K1   = GAUSS_K1,
  parameter int unsigned K2   = GAUSS_K2,
  parameter int unsigned K3   = GAUSS_K3,
  parameter int unsigned K4   = GAUSS_K4,
  parameter int unsigned K5   = GAUSS_K5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [IN_W-1:0]     x [WIN],
  output logic [IN_W+8-1:0]   y
);

  localparam int unsigned OUT_W = IN_W + 8;
  localparam int unsigned KK [6] = '{K0, K1, K2, K3, K4, K5};

  logic [IN_W-1:0]  ctr_q;
  logic [IN_W:0]    pre_q [5];
  logic [OUT_W-1:0] mac_d;

  always_ff @(posedge clk) begin
    if (!rst) begin
      ctr_q <= '0;
      for (int k = 0; k < 5; k++) pre_q[k] <= '0;
      y <= '0;
    end else begin
      ctr_q <= x[5];
      for (int k = 1; k <= 5; k++) begin
        pre_q[k-1] <= {1'b0, x[5-k]} + {1'b0, x[5+k]};
      end
      y <= mac_d;
    end
  end

  // Taps sum to 256, so the full-precision sum always fits in OUT_W bits.
  always_comb begin
    mac_d = OUT_W'(KK[0]) * OUT_W'(ctr_q);
    for (int k = 1; k <= 5; k++) begin
      mac_d = mac_d + OUT_W'(KK[k]) * OUT_W'(pre_q[k-1]);
    end
  end

endmodule

// File: rtl/gauss_blur11x11.sv
// Pipelined separable 11x11 Gaussian blur: input register, 11 vertical FIRs,
// one horizontal FIR, then round/saturate. Five clocks from input register to dout.
module gauss_blur11x11
  import sift_pkg::*;
#(
  parameter int unsigned K0 = GAUSS_K0,
  parameter int unsigned K1 = GAUSS_K1,
  parameter int unsigned K2 = GAUSS_K2,
  parameter int unsigned K3 = GAUSS_K3,
  parameter int unsigned K4 = GAUSS_K4,
  parameter int unsigned K5 = GAUSS_K5
) (
  input logic               clk,
  input logic               rst,
  gauss_blur11x11_if.slave  bus
);

  if (K0 + 2 * (K1 + K2 + K3 + K4 + K5) != 256) begin : g_kernel_check
    $error("gauss_blur11x11: kernel taps must sum to 256");
  end

  logic [ROW_W-1:0]   win_in [WIN];
  logic [ROW_W-1:0]   row_q  [WIN];
  logic [5:0]         vld_q;
  logic [5:0]         fe_q;
  logic [PIX_W+7:0]   v [WIN];
  logic [PIX_W+15:0]  h;
  logic [PIX_W+16:0]  rnd;
  logic [8:0]         quo;
  logic [PIX_W-1:0]   dout_d, dout_q;
  logic [CNT_W-1:0]   cnt_d, cnt_q;

  assign win_in[0]  = bus.win1;
  assign win_in[1]  = bus.win2;
  assign win_in[2]  = bus.win3;
  assign win_in[3]  = bus.win4;
  assign win_in[4]  = bus.win5;
  assign win_in[5]  = bus.win6;
  assign win_in[6]  = bus.win7;
  assign win_in[7]  = bus.win8;
  assign win_in[8]  = bus.win9;
  assign win_in[9]  = bus.win10;
  assign win_in[10] = bus.win11;

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int r = 0; r < WIN; r++) row_q[r] <= '0;
      vld_q  <= '0;
      fe_q   <= '0;
      dout_q <= '0;
      cnt_q  <= '0;
    end else begin
      row_q  <= win_in;
      vld_q  <= {vld_q[4:0], bus.win_valid};
      fe_q   <= {fe_q[4:0], bus.win_valid & bus.frame_end};
      dout_q <= dout_d;
      cnt_q  <= cnt_d;
    end
  end

  for (genvar c = 0; c < WIN; c++) begin : g_col
    logic [PIX_W-1:0] col [WIN];

    always_comb begin
      for (int r = 0; r < WIN; r++) col[r] = win_pix(row_q[r], c);
    end

    gauss_fir11 #(
      .IN_W (PIX_W),
      .K0   (K0),
      .K1   (K1),
      .K2   (K2),
      .K3   (K3),
      .K4   (K4),
      .K5   (K5)
    ) u_vfir (
      .clk (clk),
      .rst (rst),
      .x   (col),
      .y   (v[c])
    );
  end

  gauss_fir11 #(
    .IN_W (PIX_W + 8),
    .K0   (K0),
    .K1   (K1),
    .K2   (K2),
    .K3   (K3),
    .K4   (K4),
    .K5   (K5)
  ) u_hfir (
    .clk (clk),
    .rst (rst),
    .x   (v),
    .y   (h)
  );

  // Round half-up by adding 0.5 in the 16-bit fraction, then saturate.
  always_comb begin
    rnd    = {1'b0, h} + (PIX_W+17)'(32768);
    quo    = 9'(rnd >> 16);
    dout_d = (quo > 9'd255) ? 8'hff : quo[7:0];
  end

  // The count restarts in the cycle after the frame's last output.
  always_comb begin
    cnt_d = fe_q[5] ? '0 : cnt_q;
    cnt_d = cnt_d + CNT_W'(vld_q[4]);
  end

  assign bus.dout       = dout_q;
  assign bus.dout_valid = vld_q[5];
  assign bus.frame_done = fe_q[5];
  assign bus.out_cnt    = cnt_q;

endmodule

// File: tb/tb_gauss_blur11x11.sv
// Bench for gauss_blur11x11: directed vector table, hand sequences and random
// traffic, all scored against a direct 2-D Gaussian reference model.
module tb_gauss_blur11x11;

  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  gauss_blur11x11_if bus ();

  gauss_blur11x11 dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int due;
    bit fe;
    int pix;
  } exp_t;

  typedef struct {
    string      name;
    bit         uni;
    int         r;
    int         c;
    logic [7:0] val;
    int         exp;
  } vec_t;

  exp_t       q [$];
  int         kk [6] = '{64, 53, 29, 11, 3, 0};
  logic [7:0] win_arr [11][11];
  vec_t       tbl [12];
  int         cyc = 0;
  int         n_chk = 0;
  int         n_pass = 0;
  int         cnt_m = 0;
  bit         fd_prev = 1'b0;
  int         vld_seen = 0;
  int         fd_seen = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  // Full 2-D convolution with the outer-product kernel, then round and clamp.
  function automatic int ref_pix();
    longint h = 0;
    longint r;
    for (int i = 0; i < 11; i++) begin
      for (int j = 0; j < 11; j++) begin
        h += longint'(kk[(i > 5) ? i - 5 : 5 - i]) * longint'(kk[(j > 5) ? j - 5 : 5 - j])
             * longint'(win_arr[i][j]);
      end
    end
    r = (h + 32768) >>> 16;
    return (r > 255) ? 255 : int'(r);
  endfunction

  function automatic logic [87:0] pack_row(input int r);
    logic [87:0] row;
    for (int j = 0; j < 11; j++) row[8*j +: 8] = win_arr[r][j];
    return row;
  endfunction

  task automatic drive_rows();
    bus.win1  = pack_row(0);
    bus.win2  = pack_row(1);
    bus.win3  = pack_row(2);
    bus.win4  = pack_row(3);
    bus.win5  = pack_row(4);
    bus.win6  = pack_row(5);
    bus.win7  = pack_row(6);
    bus.win8  = pack_row(7);
    bus.win9  = pack_row(8);
    bus.win10 = pack_row(9);
    bus.win11 = pack_row(10);
  endtask

  task automatic set_win(input bit uni, input logic [7:0] val, input int r, input int c);
    for (int i = 0; i < 11; i++)
      for (int j = 0; j < 11; j++) win_arr[i][j] = uni ? val : 8'd0;
    if (!uni) win_arr[r][c] = val;
  endtask

  task automatic rand_win();
    for (int i = 0; i < 11; i++)
      for (int j = 0; j < 11; j++) win_arr[i][j] = 8'($urandom_range(0, 255));
  endtask

  // Drive one input cycle, clock it, then score every output against the model.
  task automatic step(input bit v, input bit fe, input bit rst_v);
    bit   ev;
    exp_t e;
    e = '{due: 0, fe: 1'b0, pix: 0};
    rst = rst_v;
    bus.win_valid = v;
    bus.frame_end = fe;
    drive_rows();
    if (!rst_v) begin
      q.delete();
      cnt_m   = 0;
      fd_prev = 1'b0;
    end else if (v) begin
      q.push_back('{due: cyc + 6, fe: fe, pix: ref_pix()});
    end
    @(posedge clk);
    cyc++;
    #1;
    ev = (q.size() > 0) && (q[0].due == cyc);
    if (ev) e = q.pop_front();
    if (fd_prev) cnt_m = 0;
    if (ev) cnt_m = (cnt_m + 1) % (1 << 21);
    chk("dout_valid", bus.dout_valid, ev);
    chk("frame_done", bus.frame_done, ev && e.fe);
    chk("out_cnt", bus.out_cnt, cnt_m);
    if (ev) chk("dout", bus.dout, e.pix);
    fd_prev = ev && e.fe;
    if (bus.dout_valid) vld_seen++;
    if (bus.frame_done) fd_seen++;
  endtask

  initial begin
    int  base;
    bit  pat [6];

    tbl[0]  = '{name: "uni0",     uni: 1'b1, r: 0, c: 0, val: 8'd0,   exp: 0};
    tbl[1]  = '{name: "uni1",     uni: 1'b1, r: 0, c: 0, val: 8'd1,   exp: 1};
    tbl[2]  = '{name: "uni100",   uni: 1'b1, r: 0, c: 0, val: 8'd100, exp: 100};
    tbl[3]  = '{name: "uni255",   uni: 1'b1, r: 0, c: 0, val: 8'd255, exp: 255};
    tbl[4]  = '{name: "imp_c",    uni: 1'b0, r: 5, c: 5, val: 8'd255, exp: 16};
    tbl[5]  = '{name: "imp_r5c5", uni: 1'b0, r: 4, c: 5, val: 8'd255, exp: 13};
    tbl[6]  = '{name: "imp_r6c4", uni: 1'b0, r: 5, c: 4, val: 8'd255, exp: 13};
    tbl[7]  = '{name: "imp_r6c7", uni: 1'b0, r: 5, c: 7, val: 8'd255, exp: 7};
    tbl[8]  = '{name: "imp_r7c3", uni: 1'b0, r: 6, c: 3, val: 8'd255, exp: 6};
    tbl[9]  = '{name: "imp_r2c5", uni: 1'b0, r: 1, c: 5, val: 8'd255, exp: 1};
    tbl[10] = '{name: "imp_r4c8", uni: 1'b0, r: 3, c: 8, val: 8'd255, exp: 1};
    tbl[11] = '{name: "imp_r1c0", uni: 1'b0, r: 0, c: 0, val: 8'd255, exp: 0};

    set_win(1'b1, 8'd0, 0, 0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    chk("reset_dout", bus.dout, 0);

    // Single windows with hand-computed results, exactly five clocks later.
    foreach (tbl[i]) begin
      set_win(tbl[i].uni, tbl[i].val, tbl[i].r, tbl[i].c);
      step(1'b1, 1'b0, 1'b1);
      repeat (4) step(1'b0, 1'b0, 1'b1);
      chk({tbl[i].name, "_early"}, bus.dout_valid, 0);
      step(1'b0, 1'b0, 1'b1);
      chk({tbl[i].name, "_valid"}, bus.dout_valid, 1);
      chk(tbl[i].name, bus.dout, tbl[i].exp);
    end

    // Continuous stream of flat windows.
    step(1'b0, 1'b0, 1'b0);
    set_win(1'b1, 8'd100, 0, 0);
    repeat (20) step(1'b1, 1'b0, 1'b1);
    repeat (6) step(1'b0, 1'b0, 1'b1);
    chk("stream_cnt", bus.out_cnt, 20);

    // Bubble pattern is reproduced at the output.
    step(1'b0, 1'b0, 1'b0);
    pat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    base = vld_seen;
    foreach (pat[i]) begin
      rand_win();
      step(pat[i], 1'b0, 1'b1);
    end
    repeat (6) step(1'b0, 1'b0, 1'b1);
    chk("pattern_cnt", bus.out_cnt, 4);
    chk("pattern_seen", vld_seen - base, 4);

    // Eight-window frame, then idle.
    step(1'b0, 1'b0, 1'b0);
    base = fd_seen;
    for (int i = 0; i < 8; i++) begin
      rand_win();
      step(1'b1, i == 7, 1'b1);
    end
    repeat (6) step(1'b0, 1'b0, 1'b1);
    chk("frame_pulses", fd_seen - base, 1);
    chk("frame_cnt_after", bus.out_cnt, 0);

    // Reset with three windows in flight: nothing may emerge.
    step(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      rand_win();
      step(1'b1, 1'b0, 1'b1);
    end
    step(1'b1, 1'b0, 1'b0);
    base = vld_seen;
    repeat (6) step(1'b0, 1'b0, 1'b1);
    chk("flush_seen", vld_seen - base, 0);
    rand_win();
    step(1'b1, 1'b0, 1'b1);
    repeat (5) step(1'b0, 1'b0, 1'b1);
    chk("flush_restart_cnt", bus.out_cnt, 1);

    // Random traffic, stray frame_end and occasional reset.
    for (int i = 0; i < 400; i++) begin
      rand_win();
      step(($urandom % 10) < 7, ($urandom % 8) == 0, ($urandom % 60) != 0);
    end
    repeat (6) step(1'b0, 1'b0, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
